// File: rtl/mux_scan_if.sv
// mux_scan_if: mux select/feedback and sample valid/ready bundle; smp_cnt exists only with MUX_SCAN_STATS_EN
interface mux_scan_if;
  logic       run;
  logic [3:0] ch_en;
  logic       I0;
  logic       I1;
  logic       Q;
  logic       smp_data;
  logic [1:0] smp_ch;
  logic       smp_valid;
  logic       smp_ready;
`ifdef MUX_SCAN_STATS_EN
  logic [15:0] smp_cnt;
`endif
  modport master (
    input  run, ch_en, Q, smp_ready,
`ifdef MUX_SCAN_STATS_EN
    output smp_cnt,
`endif
    output I0, I1, smp_data, smp_ch, smp_valid
  );
  modport slave (
    output run, ch_en, Q, smp_ready,
`ifdef MUX_SCAN_STATS_EN
    input  smp_cnt,
`endif
    input  I0, I1, smp_data, smp_ch, smp_valid
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: round-robin 4:1 mux scanner with dwell, Q sampling and valid/ready output
// Optional handshake counter smp_cnt enabled by MUX_SCAN_STATS_EN.
module mux_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         rst,
  mux_scan_if.master  bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT} state_t;
  state_t state, state_n;
  logic [1:0] cur_ch, nxt_ch;
  logic [CNT_W-1:0] cnt;
  logic go, hs, done, sel;
  assign go   = bus.run && |bus.ch_en;
  assign hs   = bus.smp_valid && bus.smp_ready;
  assign done = cnt == CNT_W'(DWELL - 1);
  assign sel  = go && (state == IDLE || (state == PRESENT && hs));
  // Offsets scanned 4 down to 1 so the nearest enabled channel after cur_ch wins.
  always_comb begin
    nxt_ch = cur_ch;
    for (int k = 4; k >= 1; k--)
      if (bus.ch_en[cur_ch + 2'(k)]) nxt_ch = cur_ch + 2'(k);
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = go ? SETTLE : IDLE;
      SETTLE:  state_n = done ? PRESENT : SETTLE;
      PRESENT: state_n = hs ? (go ? SETTLE : IDLE) : PRESENT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cur_ch        <= 2'd3;
      bus.I1        <= 1'b1;
      bus.I0        <= 1'b0;
      bus.smp_data  <= 1'b0;
      bus.smp_ch    <= 2'd0;
      bus.smp_valid <= 1'b0;
      cnt           <= '0;
    end else begin
      state <= state_n;
      if (sel) begin
        cur_ch <= nxt_ch;
        bus.I1 <= nxt_ch[1];
        bus.I0 <= ~nxt_ch[0];
        cnt    <= '0;
      end else if (state == SETTLE && !done) begin
        cnt <= cnt + 1'b1;
      end
      if (state == SETTLE && done) begin
        bus.smp_data  <= bus.Q;
        bus.smp_ch    <= cur_ch;
        bus.smp_valid <= 1'b1;
      end else if (state == PRESENT && hs) begin
        bus.smp_valid <= 1'b0;
      end
    end
  end
`ifdef MUX_SCAN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) bus.smp_cnt <= '0;
    else if (hs) bus.smp_cnt <= bus.smp_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed plus randomized checks of mux_scan_ctrl against a channel-sequence model
module tb_mux_scan_ctrl;
  localparam int DWELL = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] d;
  int n_tests = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  always #5 clk = ~clk;
  mux_scan_if bus ();
  mux_scan_ctrl #(.DWELL(DWELL), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [1:0] ch_of(logic i1, logic i0);
    return i1 ? (i0 ? 2'd2 : 2'd3) : (i0 ? 2'd0 : 2'd1);
  endfunction
  function automatic logic [1:0] next_en(logic [1:0] c, logic [3:0] en);
    for (int k = 1; k <= 4; k++)
      if (en[(int'(c) + k) % 4]) return 2'((int'(c) + k) % 4);
    return c;
  endfunction
  assign bus.Q = d[ch_of(bus.I1, bus.I0)];
  always @(posedge clk)
    if (rst) hs_cnt <= 0;
    else if (bus.smp_valid && bus.smp_ready) hs_cnt <= hs_cnt + 1;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic expect_sample(string tag, logic [1:0] ch, int wait_exp);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.smp_valid && n < 200);
    check({tag, "_wait"}, n, wait_exp);
    check({tag, "_ch"}, bus.smp_ch, ch);
    check({tag, "_data"}, bus.smp_data, d[ch]);
    check({tag, "_sel"}, ch_of(bus.I1, bus.I0), ch);
  endtask
  initial begin
    int bad, v, gap, miss, stab_bad, n_rand;
    logic [1:0] prev, exp_ch, hold_ch;
    logic [3:0] en_sel;
    logic hold_d, pending;
    bus.run = 0; bus.ch_en = 0; bus.smp_ready = 0; d = 4'b1101;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.smp_valid, 0);
    check("rst_i1", bus.I1, 1);
    check("rst_i0", bus.I0, 0);
    check("rst_data", bus.smp_data, 0);
    check("rst_ch", bus.smp_ch, 0);
    rst = 0; bus.run = 1; bus.ch_en = 4'hF; bus.smp_ready = 1;
    expect_sample("rr0", 0, DWELL + 1);
    expect_sample("rr1", 1, DWELL + 1);
    expect_sample("rr2", 2, DWELL + 1);
    expect_sample("rr3", 3, DWELL + 1);
    expect_sample("rr4", 0, DWELL + 1);
    // Backpressure: the ch0 sample is held for 20 cycles.
    bus.smp_ready = 0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.smp_valid || bus.smp_ch !== 2'd0 || bus.smp_data !== d[0] || ch_of(bus.I1, bus.I0) !== 2'd0) bad++;
    end
    check("bp_stable", bad, 0);
    bus.smp_ready = 1;
    expect_sample("bp_next", 1, DWELL + 1);
    @(negedge clk);
    bus.run = 0;
    expect_sample("rd2", 2, DWELL);
    v = 0;
    repeat (10) begin @(negedge clk); v += int'(bus.smp_valid); end
    check("idle_valid", v, 0);
    check("idle_sel", ch_of(bus.I1, bus.I0), 2);
    bus.run = 1;
    expect_sample("rs3", 3, DWELL + 1);
    bus.smp_ready = 0;
    rst = 1;
    @(negedge clk);
    check("rp_valid", bus.smp_valid, 0);
    check("rp_i1", bus.I1, 1);
    check("rp_i0", bus.I0, 0);
    rst = 0; bus.smp_ready = 1;
    expect_sample("rp0", 0, DWELL + 1);
    bus.ch_en = 4'b1010;
    expect_sample("en_a", 1, DWELL + 1);
    expect_sample("en_b", 3, DWELL + 1);
    expect_sample("en_c", 1, DWELL + 1);
    expect_sample("en_d", 3, DWELL + 1);
    bus.ch_en = 4'b0100;
    expect_sample("one_a", 2, DWELL + 1);
    expect_sample("one_b", 2, DWELL + 1);
    // Randomized phase: expected channel follows the mask seen at each accept.
    rst = 1;
    @(negedge clk);
    rst = 0; bus.ch_en = 4'($urandom_range(1, 15));
    prev = 2'd3; en_sel = bus.ch_en; pending = 0; gap = 0;
    miss = 0; stab_bad = 0; n_rand = 0; exp_ch = 0; hold_ch = 0; hold_d = 0;
    repeat (400) begin
      @(negedge clk);
      gap++;
      if (bus.smp_valid && !pending) begin
        exp_ch = next_en(prev, en_sel);
        check("rnd_ch", bus.smp_ch, exp_ch);
        check("rnd_data", bus.smp_data, d[exp_ch]);
        check("rnd_gap", gap, DWELL + 1);
        check("rnd_sel", ch_of(bus.I1, bus.I0), exp_ch);
        hold_ch = bus.smp_ch; hold_d = bus.smp_data; pending = 1;
      end else if (pending) begin
        if (!bus.smp_valid || bus.smp_ch !== hold_ch || bus.smp_data !== hold_d || ch_of(bus.I1, bus.I0) !== hold_ch) stab_bad++;
      end else if (gap > DWELL + 1) begin
        miss++;
      end
      bus.smp_ready = 1'($urandom);
      d = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus.ch_en = 4'($urandom_range(1, 15));
      if (pending && bus.smp_ready) begin
        prev = exp_ch; en_sel = bus.ch_en; pending = 0; gap = 0; n_rand++;
      end
    end
    check("rnd_stable", stab_bad, 0);
    check("rnd_missing", miss, 0);
    check("rnd_progress", n_rand > 20, 1);
`ifdef MUX_SCAN_STATS_EN
    @(negedge clk);
    check("stats_cnt", bus.smp_cnt, 32'(16'(hs_cnt)));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
